// File: rtl/cp0_exception_unit_pkg.sv
// Shared constants and helpers for the CP0 exception unit: register select
// encodings, instruction field positions and the Cause priority encoder.
package cp0_exception_unit_pkg;

    localparam logic [1:0] SEL_EPC    = 2'd0;
    localparam logic [1:0] SEL_STATUS = 2'd1;
    localparam logic [1:0] SEL_BLOCK  = 2'd2;
    localparam logic [1:0] SEL_CAUSE  = 2'd3;

    localparam logic [5:0] ERET_FUNCT = 6'b011000;

    localparam int MTC0_BIT = 23;
    localparam int SEL_MSB  = 12;
    localparam int SEL_LSB  = 11;

    // Priority encoding of the raw (unmasked) request lines into Cause:
    // a higher-numbered source also sets every lower bit.
    function automatic logic [31:0] cause_encode(
        input logic src0,
        input logic src1,
        input logic src2
    );
        cause_encode = {29'b0, src2, src1 | src2, src0 | src1 | src2};
    endfunction

endpackage

// File: rtl/cp0_exception_unit_if.sv
// Bus bundle between the core and the CP0 exception unit. The master side
// (core) drives requests and instruction fields; the slave side (CP0)
// returns register data and decode/exception status.
interface cp0_exception_unit_if;

    logic        ExpSrc0;
    logic        ExpSrc1;
    logic        ExpSrc2;
    logic        enable;
    logic [31:0] Instruction;
    logic [31:0] PCin;
    logic [31:0] Din;
    logic [31:0] PCout;
    logic [31:0] Dout;
    logic        ExRegWrite;
    logic        ExpBlock;
    logic        IsEret;
    logic        HasExp;

    modport master (
        output ExpSrc0, ExpSrc1, ExpSrc2, enable, Instruction, PCin, Din,
        input  PCout, Dout, ExRegWrite, ExpBlock, IsEret, HasExp
    );

    modport slave (
        input  ExpSrc0, ExpSrc1, ExpSrc2, enable, Instruction, PCin, Din,
        output PCout, Dout, ExRegWrite, ExpBlock, IsEret, HasExp
    );

endinterface

// File: rtl/cp0_exception_unit_reg32.sv
// Generic 32-bit register with load enable and synchronous active-low clear.
module reg32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] d,
    output logic [31:0] q
);

    // Clear on reset, otherwise load d when enabled and hold otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= 32'h0000_0000;
        end else if (we) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 exception unit: decodes mfc0/mtc0/eret fields, holds EPC, Status,
// Block and Cause, and turns a rising masked exception request into a
// one-cycle HasExp strobe that captures PCin into EPC.
module cp0_exception_unit
    import cp0_exception_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    cp0_exception_unit_if.slave  bus
);

    logic [1:0]  sel_s;
    logic        mtc0_s;
    logic        req_s;
    logic        accept_s;
    logic        epc_we_s;
    logic [31:0] epc_d_s;
    logic        status_we_s;
    logic        block_we_s;
    logic [31:0] cause_d_s;
    logic [31:0] dout_s;

    logic [31:0] epc_r;
    logic [31:0] status_r;
    logic [31:0] block_r;
    logic [31:0] cause_r;
    logic        req_q_r;
    logic        pending_r;

    assign sel_s  = bus.Instruction[SEL_MSB:SEL_LSB];
    assign mtc0_s = bus.enable & bus.Instruction[MTC0_BIT];

    // Masking uses the current Block/Status values, so a write landing on
    // the same edge as a request edge does not affect that request.
    assign req_s    = (bus.ExpSrc0 & ~block_r[0])
                    | (bus.ExpSrc1 & ~block_r[1])
                    | (bus.ExpSrc2 & ~block_r[2]);
    assign accept_s = req_s & ~req_q_r & ~status_r[0] & ~pending_r;

    // Register write enables; the exception capture of PCin wins over mtc0 to EPC.
    always_comb begin
        epc_we_s    = 1'b0;
        epc_d_s     = bus.Din;
        status_we_s = 1'b0;
        block_we_s  = 1'b0;
        if (pending_r) begin
            epc_we_s = 1'b1;
            epc_d_s  = bus.PCin;
        end else if (mtc0_s && (sel_s == SEL_EPC)) begin
            epc_we_s = 1'b1;
            epc_d_s  = bus.Din;
        end else begin
            epc_we_s = 1'b0;
            epc_d_s  = bus.Din;
        end
        if (mtc0_s && (sel_s == SEL_STATUS)) begin
            status_we_s = 1'b1;
        end else begin
            status_we_s = 1'b0;
        end
        if (mtc0_s && (sel_s == SEL_BLOCK)) begin
            block_we_s = 1'b1;
        end else begin
            block_we_s = 1'b0;
        end
    end

    assign cause_d_s = cause_encode(bus.ExpSrc0, bus.ExpSrc1, bus.ExpSrc2);

    reg32 u_epc (
        .clk   (clk),
        .reset (reset),
        .we    (epc_we_s),
        .d     (epc_d_s),
        .q     (epc_r)
    );

    reg32 u_status (
        .clk   (clk),
        .reset (reset),
        .we    (status_we_s),
        .d     (bus.Din),
        .q     (status_r)
    );

    reg32 u_block (
        .clk   (clk),
        .reset (reset),
        .we    (block_we_s),
        .d     (bus.Din),
        .q     (block_r)
    );

    reg32 u_cause (
        .clk   (clk),
        .reset (reset),
        .we    (accept_s),
        .d     (cause_d_s),
        .q     (cause_r)
    );

    // Request edge history and one-cycle pending flag; pending never
    // lasts more than a cycle because acceptance requires it to be clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_q_r   <= 1'b0;
            pending_r <= 1'b0;
        end else if (pending_r) begin
            req_q_r   <= req_s;
            pending_r <= 1'b0;
        end else begin
            req_q_r   <= req_s;
            pending_r <= accept_s;
        end
    end

    // mfc0 read mux over the four CP0 registers.
    always_comb begin
        dout_s = 32'h0000_0000;
        case (sel_s)
            SEL_EPC:    dout_s = epc_r;
            SEL_STATUS: dout_s = status_r;
            SEL_BLOCK:  dout_s = block_r;
            SEL_CAUSE:  dout_s = cause_r;
            default:    dout_s = 32'h0000_0000;
        endcase
    end

    assign bus.Dout       = dout_s;
    assign bus.PCout      = epc_r;
    assign bus.ExpBlock   = status_r[0];
    assign bus.HasExp     = pending_r;
    assign bus.ExRegWrite = ~bus.Instruction[MTC0_BIT];
    assign bus.IsEret     = (bus.Instruction[5:0] == ERET_FUNCT);

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Scoreboard bench for cp0_exception_unit: stimulus pushes expected values,
// a negedge monitor pops and compares them, and a second queue holds the
// expected Dout for every HasExp strobe the stimulus intends to cause.
module tb_cp0_exception_unit;

    localparam int F_DOUT   = 0;
    localparam int F_PCOUT  = 1;
    localparam int F_EXPBLK = 2;
    localparam int F_HASEXP = 3;
    localparam int F_ISERET = 4;
    localparam int F_EXRW   = 5;

    typedef struct {
        string       name;
        int          field;
        logic [31:0] exp;
    } chk_t;

    logic clk;
    logic reset;
    int   n_vec  = 0;
    int   n_fail = 0;

    chk_t        chk_q[$];
    logic [31:0] exc_q[$];

    cp0_exception_unit_if bus();

    cp0_exception_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk_instr(input logic mtc0, input logic [1:0] sel,
                                             input logic [5:0] funct);
        logic [31:0] r;
        r        = 32'h0000_0000;
        r[23]    = mtc0;
        r[12:11] = sel;
        r[5:0]   = funct;
        return r;
    endfunction

    task automatic expect_val(input string name, input int field, input logic [31:0] exp);
        chk_t c;
        c.name  = name;
        c.field = field;
        c.exp   = exp;
        chk_q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare queued expectations and police every HasExp strobe.
    always @(negedge clk) begin
        logic [31:0] act;
        logic [31:0] e;
        while (chk_q.size() > 0) begin
            chk_t c;
            c = chk_q.pop_front();
            case (c.field)
                F_DOUT:   act = bus.Dout;
                F_PCOUT:  act = bus.PCout;
                F_EXPBLK: act = {31'b0, bus.ExpBlock};
                F_HASEXP: act = {31'b0, bus.HasExp};
                F_ISERET: act = {31'b0, bus.IsEret};
                default:  act = {31'b0, bus.ExRegWrite};
            endcase
            n_vec++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, required %h", c.name, act, c.exp);
            end
        end
        if (bus.HasExp === 1'b1) begin
            n_vec++;
            if (exc_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_hasexp: got HasExp=1, required 0 at %0t", $time);
            end else begin
                e = exc_q.pop_front();
                if (bus.Dout !== e) begin
                    n_fail++;
                    $display("FAIL exc_dout: got %h, required %h", bus.Dout, e);
                end
            end
        end
    end

    initial begin
        reset           = 1'b0;
        bus.ExpSrc0     = 1'b0;
        bus.ExpSrc1     = 1'b0;
        bus.ExpSrc2     = 1'b0;
        bus.enable      = 1'b0;
        bus.Instruction = 32'h0000_0000;
        bus.PCin        = 32'h0000_0000;
        bus.Din         = 32'h0000_0000;

        // Reset and read-back of all four registers.
        tick();
        reset = 1'b1;
        for (int s = 0; s < 4; s++) begin
            bus.Instruction = mk_instr(1'b0, s[1:0], 6'd0);
            expect_val($sformatf("reset_dout_sel%0d", s), F_DOUT, 32'h0);
            if (s == 0) begin
                expect_val("reset_hasexp", F_HASEXP, 32'h0);
                expect_val("reset_expblock", F_EXPBLK, 32'h0);
                expect_val("reset_pcout", F_PCOUT, 32'h0);
                expect_val("mfc0_exregwrite", F_EXRW, 32'h1);
            end
            tick();
        end

        // Status[0] blocks exceptions.
        bus.enable = 1'b1; bus.Instruction = mk_instr(1'b1, 2'd1, 6'd0); bus.Din = 32'h1;
        expect_val("mtc0_exregwrite", F_EXRW, 32'h0);
        tick();
        bus.enable = 1'b0; bus.Instruction = mk_instr(1'b0, 2'd1, 6'd0);
        expect_val("status_expblock", F_EXPBLK, 32'h1);
        expect_val("status_readback", F_DOUT, 32'h1);
        bus.ExpSrc0 = 1'b1;
        tick();
        bus.ExpSrc0 = 1'b0;
        tick();
        bus.Instruction = mk_instr(1'b0, 2'd3, 6'd0);
        expect_val("blocked_cause", F_DOUT, 32'h0);
        tick();

        // Exception from source 0, held three cycles.
        bus.enable = 1'b1; bus.Instruction = mk_instr(1'b1, 2'd1, 6'd0); bus.Din = 32'h0;
        tick();
        bus.enable = 1'b0; bus.Instruction = mk_instr(1'b0, 2'd3, 6'd0);
        bus.PCin = 32'hDEAD_BEEF; bus.ExpSrc0 = 1'b1;
        exc_q.push_back(32'h1);
        tick();
        tick();
        expect_val("src0_pcout", F_PCOUT, 32'hDEAD_BEEF);
        expect_val("src0_hasexp_off", F_HASEXP, 32'h0);
        expect_val("src0_cause", F_DOUT, 32'h1);
        tick();
        bus.ExpSrc0 = 1'b0;
        tick();

        // Priority encoding from source 2.
        bus.PCin = 32'h0040_0100; bus.ExpSrc2 = 1'b1;
        exc_q.push_back(32'h7);
        tick();
        bus.ExpSrc2 = 1'b0;
        tick();
        expect_val("src2_cause", F_DOUT, 32'h7);
        expect_val("src2_pcout", F_PCOUT, 32'h0040_0100);
        tick();

        // Block mask.
        bus.enable = 1'b1; bus.Instruction = mk_instr(1'b1, 2'd2, 6'd0); bus.Din = 32'hBEEF_BEEF;
        tick();
        bus.enable = 1'b0; bus.Instruction = mk_instr(1'b0, 2'd2, 6'd0);
        expect_val("block_readback", F_DOUT, 32'hBEEF_BEEF);
        bus.ExpSrc0 = 1'b1;
        tick();
        bus.ExpSrc0 = 1'b0; bus.ExpSrc1 = 1'b1;
        tick();
        bus.ExpSrc1 = 1'b0;
        tick();
        bus.enable = 1'b1; bus.Instruction = mk_instr(1'b1, 2'd2, 6'd0); bus.Din = 32'h0;
        tick();
        bus.enable = 1'b0; bus.Instruction = mk_instr(1'b0, 2'd3, 6'd0); bus.ExpSrc1 = 1'b1;
        exc_q.push_back(32'h3);
        tick();
        bus.ExpSrc1 = 1'b0;
        tick();
        expect_val("src1_cause", F_DOUT, 32'h3);
        tick();

        // Plain mtc0 to EPC.
        bus.enable = 1'b1; bus.Instruction = mk_instr(1'b1, 2'd0, 6'd0); bus.Din = 32'h1234;
        tick();
        bus.enable = 1'b0; bus.Instruction = mk_instr(1'b0, 2'd0, 6'd0);
        expect_val("mtc0_epc_pcout", F_PCOUT, 32'h1234);
        expect_val("mtc0_epc_dout", F_DOUT, 32'h1234);
        tick();

        // Exception capture beats a simultaneous mtc0 to EPC.
        bus.PCin = 32'hCAFE_0000; bus.ExpSrc0 = 1'b1;
        exc_q.push_back(32'h1234);
        tick();
        bus.enable = 1'b1; bus.Instruction = mk_instr(1'b1, 2'd0, 6'd0); bus.Din = 32'h5678;
        tick();
        bus.enable = 1'b0; bus.Instruction = mk_instr(1'b0, 2'd0, 6'd0);
        expect_val("epc_prio_pcout", F_PCOUT, 32'hCAFE_0000);
        expect_val("epc_prio_dout", F_DOUT, 32'hCAFE_0000);
        bus.ExpSrc0 = 1'b0;
        tick();

        // Decode outputs, independent of enable.
        bus.Instruction = mk_instr(1'b0, 2'd0, 6'b011000);
        expect_val("eret_iseret", F_ISERET, 32'h1);
        expect_val("eret_exregwrite", F_EXRW, 32'h1);
        tick();
        bus.Instruction = mk_instr(1'b1, 2'd0, 6'b011001);
        expect_val("noteret_iseret", F_ISERET, 32'h0);
        expect_val("noteret_exregwrite", F_EXRW, 32'h0);
        tick();

        // Rising request coincident with a Status-set write is still taken.
        bus.enable = 1'b1; bus.Instruction = mk_instr(1'b1, 2'd1, 6'd0); bus.Din = 32'h1;
        bus.ExpSrc0 = 1'b1;
        exc_q.push_back(32'h1);
        tick();
        bus.enable = 1'b0; bus.Instruction = mk_instr(1'b0, 2'd3, 6'd0);
        expect_val("coincident_expblock", F_EXPBLK, 32'h1);
        tick();
        bus.ExpSrc0 = 1'b0;
        tick();

        // Reset clears everything again.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.Instruction = mk_instr(1'b0, 2'd1, 6'd0);
        expect_val("rereset_status", F_DOUT, 32'h0);
        expect_val("rereset_expblock", F_EXPBLK, 32'h0);
        expect_val("rereset_pcout", F_PCOUT, 32'h0);
        tick();
        tick();

        n_vec++;
        if (exc_q.size() != 0) begin
            n_fail++;
            $display("FAIL missed_exceptions: got %0d outstanding, required 0", exc_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_exception_unit.md
# cp0_exception_unit

Coprocessor-0 block for the MIPS core: decodes the CP0 fields of the current instruction (mfc0/mtc0/eret) and holds the EPC, Status, Block and Cause registers. It also arbitrates three exception sources and raises a one-cycle exception strobe that captures the faulting PC. It sits beside the register file and PC logic. `PCout` feeds the PC mux on eret and exception vectoring, and `Dout` feeds the register-file write-back on mfc0.

## Interface
- No parameters.
- `clk` — input, 1 bit. Single clock; all state updates on its rising edge.
- `reset` — input, 1 bit. Synchronous, active-low.
- `ExpSrc0`, `ExpSrc1`, `ExpSrc2` — input, 1 bit each. Exception request lines, level.
- `enable` — input, 1 bit. CP0 instruction is valid this cycle.
- `Instruction` — input, 32 bits. Current instruction word.
- `PCin` — input, 32 bits. PC to save into EPC on exception.
- `Din` — input, 32 bits. GPR data for mtc0.
- `PCout` — output, 32 bits. Current EPC value.
- `Dout` — output, 32 bits. Selected CP0 register for mfc0.
- `ExRegWrite` — output, 1 bit. GPR write-back request (mfc0) = `~Instruction[23]`.
- `ExpBlock` — output, 1 bit. `Status[0]`, global exception disable.
- `IsEret` — output, 1 bit. `Instruction[5:0] == 6'b011000`.
- `HasExp` — output, 1 bit. Exception-taken strobe.

## Operation
- `sel = Instruction[12:11]`:
  - 0 = EPC
  - 1 = Status
  - 2 = Block
  - 3 = Cause
- `ExRegWrite` and `IsEret` are purely combinational decodes and are independent of `enable`.
- CP0 write (mtc0) occurs when `enable & Instruction[23]`:
  - sel 0 writes EPC, sel 1 writes Status, sel 2 writes Block.
  - sel 3 is ignored; Cause is read-only.
- `Dout` is a combinational mux of the four registers by `sel`. `PCout` is always EPC.
- Masked request: `req = (ExpSrc0 & ~Block[0]) | (ExpSrc1 & ~Block[1]) | (ExpSrc2 & ~Block[2])`.
- Acceptance: a rising edge of `req`, i.e. `req & ~req_q` where `req_q` is `req` registered, while `ExpBlock == 0` and no exception is pending.
  - A level held high triggers once only.
  - Requests arriving while pending, or while `ExpBlock == 1`, are dropped, not queued.
- On acceptance:
  - Cause ← `{29'b0, ExpSrc2, ExpSrc1|ExpSrc2, ExpSrc0|ExpSrc1|ExpSrc2}`. Raw, unmasked inputs; this is a priority encoding.
  - The pending flag is set.
- `HasExp` equals the pending flag.
- While `HasExp == 1`:
  - EPC ← `PCin`. This has priority over a simultaneous mtc0 to EPC, which is discarded.
  - The pending flag clears at the same edge.

## Timing
- Reset (`reset == 0` at a clock edge) clears EPC, Status, Block, Cause, the pending flag and `req_q`.
- Post-reset outputs: `PCout = 0`, `Dout = 0`, `ExpBlock = 0`, `HasExp = 0`. Decode outputs follow `Instruction` combinationally.
- Reset overrides every simultaneous write or exception.
- Register writes are visible on `Dout`/`PCout`/`ExpBlock` one cycle after the write edge.
- Exception timeline:
  - Request edge sampled at edge N: Cause updated, `HasExp = 1` during cycle N→N+1.
  - Edge N+1: EPC ← `PCin`, `HasExp` returns to 0.
  - `PCout` shows the new EPC from N+1.
- Writing Status/Block at edge N affects masking from cycle N+1.
- A rising request coincident with a Status-set write is still accepted, because masking uses current register values.

## Structure
- Shared package:
  - sel encodings `SEL_EPC = 2'd0`, `SEL_STATUS = 2'd1`, `SEL_BLOCK = 2'd2`, `SEL_CAUSE = 2'd3`.
  - `ERET_FUNCT = 6'b011000`.
  - Bit positions `MTC0_BIT = 23` and `SEL_MSB/LSB = 12/11`.
- One sub-module, `reg32`:
  - 32-bit register with write enable and synchronous active-low reset to 0.
  - Instantiated four times (EPC, Status, Block, Cause).
- The pending flag and edge detector are inline logic; no gated or derived clocks.

## Test plan
- **Reset and read-back:** reset low for 1 cycle, then read sel 0..3 → all `Dout = 0`, `HasExp = 0`, `ExpBlock = 0`.
- **Status blocks exceptions:** mtc0 sel 1, `Din = 0x1` → `ExpBlock = 1`. Then pulse `ExpSrc0` → `HasExp` stays 0, Cause stays 0.
- **Exception from source 0:** Status = 0, `PCin = 0xDEADBEEF`, raise `ExpSrc0` and hold 3 cycles.
  - `HasExp` is high for exactly one cycle.
  - Cause = `0x1`; `PCout = 0xDEADBEEF`.
  - No retrigger while held.
- **Priority encoding from source 2:** `ExpSrc2` pulse → Cause = `0x7`.
- **Block mask:** mtc0 sel 2, `Din = 0xBEEFBEEF` → read back `0xBEEFBEEF`. Then `ExpSrc0` → no `HasExp` (Block[0] = 1), while `ExpSrc1`... blocked too (Block[1] = 1). Then Block = 0 and `ExpSrc1` → Cause = `0x3`.
- **Decode and EPC priority:**
  - `Instruction[5:0] = 6'b011000` → `IsEret = 1`.
  - mtc0 EPC `Din = 0x1234` in the same cycle as `HasExp` → EPC = `PCin`, not `0x1234`.
  - `Instruction[23] = 0` → `ExRegWrite = 1`.
